encrypt_arbiter: RTL and testbench
==================================

ENCRYPT_ARBITER -- requirements
Module: encrypt_arbiter

Interface
REQ-001 Parameter N_K, default 80, key width in bits.
REQ-002 Parameter N_B, default 64, block width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0, req1  input  1 each  per-requester encryption request.
REQ-006 k0, k1  input  N_K each  per-requester key, stable while reqN high.
REQ-007 m0, m1  input  N_B each  per-requester plaintext, stable while reqN high.
REQ-008 ack0, ack1  output  1 each  per-requester completion.
REQ-009 c0, c1  output  N_B each  per-requester ciphertext, registered.
REQ-010 core_req  output  1  request to the shared encrypt core.
REQ-011 core_k  output  N_K  registered key to the core.
REQ-012 core_m  output  N_B  registered plaintext to the core.
REQ-013 core_c  input  N_B  core ciphertext, valid while core_ack high.
REQ-014 core_ack  input  1  core completion; may pulse for one cycle only.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 owner  output  1  index of the currently or last granted requester.

Function
REQ-017 FSM states: IDLE, BUSY, DONE, RELEASE; registered, one-hot or binary.
REQ-018 IDLE: no reqN high -> stay IDLE; core_req=0, ack0=ack1=0.
REQ-019 IDLE, exactly one reqN high -> grant N, load core_k<=kN, core_m<=mN, owner<=N, -> BUSY.
REQ-020 IDLE, both high -> grant requester != owner (round-robin); owner resets to 1, so requester 0 wins first contention.
REQ-021 BUSY: core_req=1 every cycle; core_k/core_m held constant.
REQ-022 BUSY, core_ack=1 and req[owner]=1 -> c[owner]<=core_c, -> DONE; other cN unchanged.
REQ-023 BUSY, req[owner]=0 (requester abort) -> -> RELEASE, no ack, cN unchanged; takes priority over simultaneous core_ack.
REQ-024 No core latency bound assumed; BUSY waits indefinitely for core_ack.
REQ-025 DONE: core_req=0 (core returns to its idle state); ack[owner]=1, registered, first high the cycle after core_ack sampled.
REQ-026 DONE: stay while req[owner]=1; req[owner]=0 -> RELEASE.
REQ-027 RELEASE: core_req=0, ack0=ack1=0 for exactly one cycle, -> IDLE.
REQ-028 Minimum gap between consecutive grants: core_req low >=1 cycle (DONE or RELEASE), guaranteeing core restart.
REQ-029 ackN never high when N != owner; ack0 and ack1 never simultaneously high.
REQ-030 Non-owner reqN changes in BUSY/DONE/RELEASE ignored; request held pending, served at next IDLE.
REQ-031 cN holds its last captured value until overwritten by a later grant to N.
REQ-032 core_c sampled only in cycle core_ack=1 in BUSY; core_ack outside BUSY ignored.

Reset
REQ-033 rst=1 at a clock edge -> state IDLE, owner=1, core_req=0, core_k=0, core_m=0, ack0=ack1=0, c0=c1=0, busy=0.
REQ-034 rst overrides all transitions; mid-BUSY reset drops core_req next cycle, discards in-flight result.
REQ-035 First grant possible in the first cycle rst=0 is sampled.

Verification (bench core model: core_ack pulses one cycle, core_c = core_m ^ core_k[N_B-1:0], 3 cycles after core_req rises)
REQ-036 req0=1, k0=80'h0, m0=64'h0123456789ABCDEF -> core_req rises next cycle; ack0=1 with c0=64'h0123456789ABCDEF; drop req0 -> ack0=0, RELEASE 1 cycle, IDLE.
REQ-037 req0=req1=1 same cycle after reset -> requester 0 served first, then 1; repeat -> 1 then 0 order preserved by round-robin.
REQ-038 req1 held high during requester 0 transaction -> req1 granted in first IDLE cycle after RELEASE; core_req low >=1 cycle between.
REQ-039 req0 dropped in BUSY cycle with core_ack=1 -> no ack0, c0 unchanged, RELEASE then IDLE.
REQ-040 rst=1 in BUSY -> all outputs to reset values next cycle; later core_ack pulse ignored, no ackN.
REQ-041 Assertions throughout: ack0&ack1 never 1; ackN implies owner=N; core_k/core_m stable while core_req=1.

Source files
------------

// File: rtl/encrypt_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared encrypt core.
// The owner's request must stay high through the transaction; dropping it aborts.
module encrypt_arbiter #(
    parameter int N_K = 80,
    parameter int N_B = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [N_K-1:0] k0,
    input  logic [N_K-1:0] k1,
    input  logic [N_B-1:0] m0,
    input  logic [N_B-1:0] m1,
    output logic           ack0,
    output logic           ack1,
    output logic [N_B-1:0] c0,
    output logic [N_B-1:0] c1,
    output logic           core_req,
    output logic [N_K-1:0] core_k,
    output logic [N_B-1:0] core_m,
    input  logic [N_B-1:0] core_c,
    input  logic           core_ack,
    output logic           busy,
    output logic           owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;
    logic [N_K-1:0] r_core_k;
    logic [N_B-1:0] r_core_m;
    logic [N_B-1:0] r_c0;
    logic [N_B-1:0] r_c1;

    logic           w_req_own;
    logic           w_load;
    logic           w_grant;
    logic           w_capture;

    assign w_req_own = r_owner ? req1 : req0;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_grant     = r_owner;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_load      = 1'b1;
                    // Contention goes to the requester that was not served last.
                    w_grant     = (req0 && req1) ? ~r_owner : req1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!w_req_own) begin
                    w_state_nxt = RELEASE;
                end else if (core_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!w_req_own) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= 1'b1;
            r_core_k <= '0;
            r_core_m <= '0;
            r_c0     <= '0;
            r_c1     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_owner  <= w_grant;
                r_core_k <= w_grant ? k1 : k0;
                r_core_m <= w_grant ? m1 : m0;
            end
            if (w_capture) begin
                if (r_owner) begin
                    r_c1 <= core_c;
                end else begin
                    r_c0 <= core_c;
                end
            end
        end
    end

    assign core_req = (r_state == BUSY);
    assign busy     = (r_state != IDLE);
    assign ack0     = (r_state == DONE) && !r_owner;
    assign ack1     = (r_state == DONE) && r_owner;
    assign owner    = r_owner;
    assign core_k   = r_core_k;
    assign core_m   = r_core_m;
    assign c0       = r_c0;
    assign c1       = r_c1;

endmodule

// File: tb/tb_encrypt_arbiter.sv
// Scoreboard bench for encrypt_arbiter with a behavioural XOR core that answers
// a few cycles after core_req rises.
module tb_encrypt_arbiter;

    localparam int N_K = 80;
    localparam int N_B = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0, req1;
    logic [N_K-1:0] k0, k1;
    logic [N_B-1:0] m0, m1;
    logic           ack0, ack1;
    logic [N_B-1:0] c0, c1;
    logic           core_req;
    logic [N_K-1:0] core_k;
    logic [N_B-1:0] core_m;
    logic [N_B-1:0] core_c;
    logic           core_ack;
    logic           busy;
    logic           owner;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int unsigned    idx;
        logic [N_B-1:0] c;
    } exp_t;
    exp_t sb[$];

    // Directed vectors; expected ciphertext is m ^ k[63:0], worked by hand.
    localparam logic [N_K-1:0] V0K = 80'h0000_0000000000000000;
    localparam logic [N_B-1:0] V0M = 64'h0123456789ABCDEF;
    localparam logic [N_B-1:0] V0C = 64'h0123456789ABCDEF;
    localparam logic [N_K-1:0] V1K = 80'hAAAA_FFFFFFFFFFFFFFFF;
    localparam logic [N_B-1:0] V1M = 64'h0123456789ABCDEF;
    localparam logic [N_B-1:0] V1C = 64'hFEDCBA9876543210;
    localparam logic [N_K-1:0] V2K = 80'h1234_00000000FFFFFFFF;
    localparam logic [N_B-1:0] V2M = 64'hDEADBEEF00000000;
    localparam logic [N_B-1:0] V2C = 64'hDEADBEEFFFFFFFFF;
    localparam logic [N_K-1:0] V3K = 80'h0000_F0F0F0F0F0F0F0F0;
    localparam logic [N_B-1:0] V3M = 64'h0F0F0F0F0F0F0F0F;
    localparam logic [N_B-1:0] V3C = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [N_K-1:0] V4K = 80'hFFFF_1111111111111111;
    localparam logic [N_B-1:0] V4M = 64'h2222222222222222;
    localparam logic [N_B-1:0] V4C = 64'h3333333333333333;

    encrypt_arbiter #(.N_K(N_K), .N_B(N_B)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .k0(k0), .k1(k1), .m0(m0), .m1(m1),
        .ack0(ack0), .ack1(ack1), .c0(c0), .c1(c1),
        .core_req(core_req), .core_k(core_k), .core_m(core_m),
        .core_c(core_c), .core_ack(core_ack),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned idx, input logic [N_B-1:0] c);
        exp_t e;
        e.idx = idx;
        e.c   = c;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int unsigned idx);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((idx == 0 && ack0) || (idx == 1 && ack1)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack%0d_timeout: got no ack expected ack within 30 cycles", idx);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     busy,     1'b0);
        check({tag, "_owner"},    owner,    1'b1);
        check({tag, "_core_req"}, core_req, 1'b0);
        check({tag, "_core_k"},   core_k,   '0);
        check({tag, "_core_m"},   core_m,   '0);
        check({tag, "_ack0"},     ack0,     1'b0);
        check({tag, "_ack1"},     ack1,     1'b0);
        check({tag, "_c0"},       c0,       '0);
        check({tag, "_c1"},       c1,       '0);
    endtask

    // Core model: one-cycle ack carrying core_m ^ core_k[63:0], 3 cycles after core_req rises.
    initial begin
        int   cnt  = 0;
        logic prev = 1'b0;
        core_ack = 1'b0;
        core_c   = '0;
        forever begin
            @(posedge clk);
            #1;
            core_ack = 1'b0;
            if (core_req && !prev) cnt = 3;
            prev = core_req;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_ack = 1'b1;
                    core_c   = core_m ^ core_k[N_B-1:0];
                end
            end
        end
    end

    // Monitor: every rising ack pops the scoreboard and checks requester and ciphertext.
    logic           mon_p0 = 1'b0, mon_p1 = 1'b0;
    logic           inv_preq = 1'b0;
    logic [N_K-1:0] inv_pk;
    logic [N_B-1:0] inv_pm;
    always @(negedge clk) begin
        if (rst) begin
            mon_p0 = 1'b0;
            mon_p1 = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                logic a, p;
                a = (n == 0) ? ack0 : ack1;
                p = (n == 0) ? mon_p0 : mon_p1;
                if (a && !p) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack%0d: got ack expected none", n);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("ack_requester", n, e.idx);
                        check("ack_owner", owner, e.idx[0]);
                        check("ack_cipher", (n == 0) ? c0 : c1, e.c);
                    end
                end
            end
            mon_p0 = ack0;
            mon_p1 = ack1;
        end
        // Invariants checked every cycle.
        assert (!(ack0 && ack1)) else begin
            n_tests++; n_fail++;
            $display("FAIL inv_ack_both: got ack0=1 ack1=1 expected at most one");
        end
        assert (!(ack0 && owner) && !(ack1 && !owner)) else begin
            n_tests++; n_fail++;
            $display("FAIL inv_ack_owner: got owner=%0d expected owner matching ack", owner);
        end
        if (!rst && inv_preq && core_req) begin
            assert (core_k == inv_pk && core_m == inv_pm) else begin
                n_tests++; n_fail++;
                $display("FAIL inv_core_stable: got k=%0h m=%0h expected k=%0h m=%0h",
                         core_k, core_m, inv_pk, inv_pm);
            end
        end
        inv_preq = core_req;
        inv_pk   = core_k;
        inv_pm   = core_m;
    end

    initial begin
        logic [N_B-1:0] c0_saved;
        bit             seen;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        k0 = '0; k1 = '0; m0 = '0; m1 = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Single request, granted in the first cycle reset is released.
        rst = 1'b0; k0 = V0K; m0 = V0M; req0 = 1'b1; push(0, V0C);
        @(negedge clk);
        check("t1_core_req", core_req, 1'b1);
        check("t1_owner", owner, 1'b0);
        check("t1_core_m", core_m, V0M);
        wait_ack(0);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_rel_ack0", ack0, 1'b0);
        check("t1_rel_busy", busy, 1'b1);
        @(negedge clk);
        check("t1_idle_busy", busy, 1'b0);

        // Contention after reset: 0 then 1.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        k0 = V1K; m0 = V1M; k1 = V2K; m1 = V2M;
        req0 = 1'b1; req1 = 1'b1; push(0, V1C); push(1, V2C);
        wait_ack(0); req0 = 1'b0;
        wait_ack(1); req1 = 1'b0;
        repeat (2) @(negedge clk);
        // Serve 0 alone, then contend again: 1 must win.
        k0 = V3K; m0 = V3M; req0 = 1'b1; push(0, V3C);
        wait_ack(0); req0 = 1'b0;
        repeat (2) @(negedge clk);
        k1 = V4K; m1 = V4M; k0 = V0K; m0 = V0M;
        req0 = 1'b1; req1 = 1'b1; push(1, V4C); push(0, V0C);
        wait_ack(1); req1 = 1'b0;
        wait_ack(0); req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Pending req1 while 0 is served; core_req gap before the next grant.
        k0 = V2K; m0 = V2M; req0 = 1'b1; push(0, V2C);
        @(negedge clk);
        k1 = V3K; m1 = V3M; req1 = 1'b1; push(1, V3C);
        wait_ack(0);
        check("t3_done_core_req", core_req, 1'b0);
        req0 = 1'b0;
        @(negedge clk);
        check("t3_rel_core_req", core_req, 1'b0);
        check("t3_rel_busy", busy, 1'b1);
        @(negedge clk);
        check("t3_idle_busy", busy, 1'b0);
        check("t3_idle_core_req", core_req, 1'b0);
        @(negedge clk);
        check("t3_grant1_core_req", core_req, 1'b1);
        check("t3_grant1_owner", owner, 1'b1);
        check("t3_grant1_core_k", core_k, V3K);
        wait_ack(1); req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Abort coinciding with core_ack: no ack, c0 keeps its old value.
        c0_saved = V2C;
        k0 = V4K; m0 = V4M; req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (core_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_core_ack_seen", seen, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        check("t4_rel_ack0", ack0, 1'b0);
        check("t4_rel_busy", busy, 1'b1);
        check("t4_c0_kept", c0, c0_saved);
        @(negedge clk);
        check("t4_idle_busy", busy, 1'b0);

        // Reset mid-BUSY; the later core_ack pulse must be ignored.
        k1 = V1K; m1 = V1M; req1 = 1'b1;
        @(negedge clk);
        check("t5_busy_core_req", core_req, 1'b1);
        rst = 1'b1; req1 = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_ack", {ack0, ack1, busy}, 3'b000);
        end
        check("t5_c1_cleared", c1, '0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
